add_order: RTL and testbench

- Insertion counterpart to the order-delete engine in the FPGA limit order book.
- On `start`, scans the selected side's order RAM (buy or sell) from address 0 for the first reusable slot. A reusable slot is an empty word (all zeros) or a deleted word (all ones).
- Writes the new 48-bit order word {id, price, qty} into that slot and reports a status code.
- Sits beside the delete engine. Both share the same RAM word format and the same start/done handshake.

---
 rtl/add_order.sv | 145 ++++++++++++++
 tb/tb_add_order.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_order.sv
// Order-book insertion engine: scans the selected side's RAM for a reusable slot and writes {id, price, qty}.
// Optional ADD_ORDER_DUP_CHECK_EN: full scan with duplicate-id rejection before insertion.
module add_order #(
  parameter int MAX_BOOK_SIZE = 10,
  parameter int ADDR_W        = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              side,
  input  logic [15:0]       id,
  input  logic [15:0]       price,
  input  logic [15:0]       qty,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [47:0]       ram_wdata,
  output logic              buy_we,
  output logic              sell_we,
  input  logic [47:0]       buy_rdata,
  input  logic [47:0]       sell_rdata,
  output logic [15:0]       success,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_BOOK_SIZE - 1);

  typedef enum logic [2:0] {IDLE, WAIT, CHECK, WRITE, DONE} state_t;

  state_t      r_state;
  logic        r_side;
  logic [47:0] w_rdata;
  logic        w_isEmpty;
  logic        w_isFree;

  assign w_rdata   = r_side ? sell_rdata : buy_rdata;
  assign w_isEmpty = (w_rdata == 48'h0);
  assign w_isFree  = w_isEmpty || (w_rdata == 48'hFFFF_FFFF_FFFF);

`ifdef ADD_ORDER_DUP_CHECK_EN
  logic              r_freeValid;
  logic [ADDR_W-1:0] r_freeAddr;
  logic              w_idMatch;
  logic              w_haveFree;
  logic [ADDR_W-1:0] w_freeAddr;

  // The latched id lives in the top field of the write word.
  assign w_idMatch  = !w_isFree && (w_rdata[47:32] == ram_wdata[47:32]);
  assign w_haveFree = r_freeValid || w_isFree;
  assign w_freeAddr = r_freeValid ? r_freeAddr : ram_addr;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_side    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      buy_we    <= 1'b0;
      sell_we   <= 1'b0;
      success   <= '0;
      done      <= 1'b0;
`ifdef ADD_ORDER_DUP_CHECK_EN
      r_freeValid <= 1'b0;
      r_freeAddr  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          success  <= '0;
          done     <= 1'b0;
          buy_we   <= 1'b0;
          sell_we  <= 1'b0;
          ram_addr <= '0;
`ifdef ADD_ORDER_DUP_CHECK_EN
          r_freeValid <= 1'b0;
`endif
          if (start) begin
            r_side    <= side;
            ram_wdata <= {id, price, qty};
            if (qty == 16'h0 || id == 16'hFFFF) begin
              success <= 16'd4;
              r_state <= DONE;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: r_state <= CHECK;
        CHECK: begin
`ifdef ADD_ORDER_DUP_CHECK_EN
          if (w_idMatch) begin
            success <= 16'd2;
            r_state <= DONE;
          end else if (w_isEmpty || ram_addr == LAST_ADDR) begin
            if (w_haveFree) begin
              ram_addr <= w_freeAddr;
              buy_we   <= !r_side;
              sell_we  <= r_side;
              r_state  <= WRITE;
            end else begin
              success <= 16'd3;
              r_state <= DONE;
            end
          end else begin
            if (w_isFree && !r_freeValid) begin
              r_freeValid <= 1'b1;
              r_freeAddr  <= ram_addr;
            end
            ram_addr <= ram_addr + ADDR_W'(1);
            r_state  <= WAIT;
          end
`else
          if (w_isFree) begin
            buy_we  <= !r_side;
            sell_we <= r_side;
            r_state <= WRITE;
          end else if (ram_addr == LAST_ADDR) begin
            success <= 16'd3;
            r_state <= DONE;
          end else begin
            ram_addr <= ram_addr + ADDR_W'(1);
            r_state  <= WAIT;
          end
`endif
        end
        WRITE: begin
          buy_we  <= 1'b0;
          sell_we <= 1'b0;
          success <= 16'd1;
          done    <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          // done must be seen high for at least one cycle before start may release it.
          done <= 1'b1;
          if (done && !start) begin
            done    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_order.sv
// Self-checking bench for add_order: behavioural order RAMs, a reference model and a scoreboard of expected results.
module tb_add_order;

  localparam int N  = 10;
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          side;
  logic [15:0]   id, price, qty;
  logic [AW-1:0] ram_addr;
  logic [47:0]   ram_wdata;
  logic          buy_we, sell_we;
  logic [47:0]   buy_rdata, sell_rdata;
  logic [15:0]   success;
  logic          done;

  add_order #(.MAX_BOOK_SIZE(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .side(side),
    .id(id), .price(price), .qty(qty),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .buy_we(buy_we), .sell_we(sell_we),
    .buy_rdata(buy_rdata), .sell_rdata(sell_rdata),
    .success(success), .done(done)
  );

  always #5 clk = ~clk;

  // Book images prepared by the stimulus, copied into the RAMs on loadReq.
  logic [47:0] bookBuy [16];
  logic [47:0] bookSell[16];
  logic [47:0] buyMem  [16];
  logic [47:0] sellMem [16];
  logic        loadReq = 1'b0;

  always @(posedge clk) begin
    if (loadReq) begin
      for (int i = 0; i < 16; i++) begin
        buyMem[i]  <= bookBuy[i];
        sellMem[i] <= bookSell[i];
      end
    end else begin
      if (buy_we)  buyMem[ram_addr[3:0]]  <= ram_wdata;
      if (sell_we) sellMem[ram_addr[3:0]] <= ram_wdata;
    end
    buy_rdata  <= buyMem[ram_addr[3:0]];
    sell_rdata <= sellMem[ram_addr[3:0]];
  end

  // Write monitor, sampled mid-cycle.
  int          buyWrCnt = 0, sellWrCnt = 0;
  int          lastWrAddr = 0;
  logic [47:0] lastWrData = '0;

  always @(negedge clk) begin
    if (buy_we) begin
      buyWrCnt   <= buyWrCnt + 1;
      lastWrAddr <= int'(ram_addr);
      lastWrData <= ram_wdata;
    end
    if (sell_we) begin
      sellWrCnt  <= sellWrCnt + 1;
      lastWrAddr <= int'(ram_addr);
      lastWrData <= ram_wdata;
    end
  end

  typedef struct {
    logic [15:0] status;
    int          doneEdge;
    bit          wr;
    bit          wrSide;
    int          wrAddr;
    logic [47:0] wrData;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   buySnap, sellSnap;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] liveWord(input int a);
    return {16'(16'h0100 + a), 16'h0010, 16'h0001};
  endfunction

  // Reference model: expected outcome of one request against the current book images.
  function automatic exp_t model(input logic s, input logic [15:0] i, input logic [15:0] p, input logic [15:0] q);
    exp_t        e;
    logic [47:0] w;
`ifdef ADD_ORDER_DUP_CHECK_EN
    int          freeA;
    freeA = -1;
`endif
    e.status = 16'd0; e.doneEdge = 0; e.wr = 1'b0; e.wrSide = s; e.wrAddr = 0; e.wrData = {i, p, q};
    if (q == 16'h0 || i == 16'hFFFF) begin
      e.status = 16'd4; e.doneEdge = 1;
      return e;
    end
    for (int a = 0; a < N; a++) begin
      w = s ? bookSell[a] : bookBuy[a];
`ifdef ADD_ORDER_DUP_CHECK_EN
      if (w != 48'h0 && w != 48'hFFFF_FFFF_FFFF && w[47:32] == i) begin
        e.status = 16'd2; e.doneEdge = 2*a + 3;
        return e;
      end
      if ((w == 48'h0 || w == 48'hFFFF_FFFF_FFFF) && freeA < 0) freeA = a;
      if (w == 48'h0 || a == N-1) begin
        if (freeA >= 0) begin
          e.status = 16'd1; e.wr = 1'b1; e.wrAddr = freeA;
        end else begin
          e.status = 16'd3;
        end
        e.doneEdge = 2*a + 3;
        return e;
      end
`else
      if (w == 48'h0 || w == 48'hFFFF_FFFF_FFFF) begin
        e.status = 16'd1; e.wr = 1'b1; e.wrAddr = a; e.doneEdge = 2*a + 3;
        return e;
      end
`endif
    end
    e.status = 16'd3; e.doneEdge = 2*N + 1;
    return e;
  endfunction

  task automatic clearBooks();
    for (int i = 0; i < 16; i++) begin
      bookBuy[i]  = '0;
      bookSell[i] = '0;
    end
  endtask

  task automatic loadBooks();
    @(negedge clk); loadReq = 1'b1;
    @(negedge clk); loadReq = 1'b0;
  endtask

  task automatic applyStimulus(input logic s, input logic [15:0] i, input logic [15:0] p, input logic [15:0] q);
    @(negedge clk);
    side = s; id = i; price = p; qty = q;
    sb.push_back(model(s, i, p, q));
    buySnap  = buyWrCnt;
    sellSnap = sellWrCnt;
    start = 1'b1;
  endtask

  // Counts edges from the sampling edge to done, then pops and compares the expectation.
  task automatic waitAndCheck(input string name);
    int   n;
    bit   got;
    exp_t e;
    @(posedge clk);
    n = 0; got = 1'b0;
    while (n < 200 && !got) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) checkOutput({name, ".timeout"}, 64'd0, 64'd1);
    if (sb.size() == 0) begin
      checkOutput({name, ".sbEmpty"}, 64'd0, 64'd1);
      start = 1'b0;
      return;
    end
    e = sb.pop_front();
    checkOutput({name, ".status"},   64'(success), 64'(e.status));
    checkOutput({name, ".doneEdge"}, 64'(n),       64'(e.doneEdge));
    checkOutput({name, ".buyWr"},  64'(buyWrCnt - buySnap),   64'(e.wr && !e.wrSide));
    checkOutput({name, ".sellWr"}, 64'(sellWrCnt - sellSnap), 64'(e.wr && e.wrSide));
    if (e.wr) begin
      checkOutput({name, ".wrAddr"}, 64'(lastWrAddr), 64'(e.wrAddr));
      checkOutput({name, ".wrData"}, 64'(lastWrData), 64'(e.wrData));
    end
    repeat (2) @(negedge clk);
    checkOutput({name, ".doneHeld"}, 64'(done), 64'd1);
    checkOutput({name, ".noRetrig"}, 64'(buyWrCnt - buySnap + sellWrCnt - sellSnap), 64'(e.wr));
    start = 1'b0;
    @(negedge clk);
    checkOutput({name, ".doneClear"}, 64'(done), 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; side = 1'b0; id = '0; price = '0; qty = '0;
    clearBooks();
    #1;
    checkOutput("rst.addr",  64'(ram_addr),  64'd0);
    checkOutput("rst.wdata", 64'(ram_wdata), 64'd0);
    checkOutput("rst.we",    64'({buy_we, sell_we}), 64'd0);
    checkOutput("rst.status", 64'(success), 64'd0);
    checkOutput("rst.done",  64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    loadBooks();

    // Empty buy book: insert at address 0.
    applyStimulus(1'b0, 16'h0005, 16'h0064, 16'h000A);
    waitAndCheck("emptyBuy");

    // Sell book with three live orders and a deleted slot at 3.
    clearBooks();
    for (int a = 0; a < 3; a++) bookSell[a] = liveWord(a);
    bookSell[3] = 48'hFFFF_FFFF_FFFF;
    loadBooks();
    applyStimulus(1'b1, 16'h0042, 16'h0123, 16'h0007);
    waitAndCheck("sellDeleted");

    // Only the last slot is free.
    clearBooks();
    for (int a = 0; a < N-1; a++) bookBuy[a] = liveWord(a);
    loadBooks();
    applyStimulus(1'b0, 16'h0033, 16'h0200, 16'h0001);
    waitAndCheck("lastSlot");

    // Full buy book.
    clearBooks();
    for (int a = 0; a < N; a++) bookBuy[a] = liveWord(a);
    loadBooks();
    applyStimulus(1'b0, 16'h0044, 16'h0300, 16'h0002);
    waitAndCheck("fullBuy");

    // Invalid orders.
    clearBooks();
    loadBooks();
    applyStimulus(1'b0, 16'h0009, 16'h0010, 16'h0000);
    waitAndCheck("qtyZero");
    applyStimulus(1'b1, 16'hFFFF, 16'h0010, 16'h0003);
    waitAndCheck("idOnes");

    // Reset during the WAIT at address 4 aborts without a write.
    clearBooks();
    for (int a = 0; a < 4; a++) bookBuy[a] = liveWord(a);
    loadBooks();
    @(negedge clk);
    side = 1'b0; id = 16'h0077; price = 16'h0055; qty = 16'h0004;
    buySnap = buyWrCnt; sellSnap = sellWrCnt;
    start = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    @(negedge clk);
    checkOutput("rstScan.addr", 64'(ram_addr), 64'd4);
    rst = 1'b0;
    #1;
    checkOutput("rstScan.ctrl", 64'({ram_addr, buy_we, sell_we, success, done}), 64'd0);
    checkOutput("rstScan.wdata", 64'(ram_wdata), 64'd0);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    checkOutput("rstScan.noWr", 64'(buyWrCnt - buySnap + sellWrCnt - sellSnap), 64'd0);
    applyStimulus(1'b0, 16'h0077, 16'h0055, 16'h0004);
    waitAndCheck("afterRst");

`ifdef ADD_ORDER_DUP_CHECK_EN
    // Duplicate detection past a deleted slot, then insertion into that slot.
    clearBooks();
    bookBuy[0] = liveWord(0);
    bookBuy[1] = 48'hFFFF_FFFF_FFFF;
    bookBuy[2] = {16'h0005, 16'h0064, 16'h000A};
    loadBooks();
    applyStimulus(1'b0, 16'h0005, 16'h0070, 16'h0001);
    waitAndCheck("dupHit");
    applyStimulus(1'b0, 16'h0006, 16'h0070, 16'h0001);
    waitAndCheck("dupMiss");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
